// File: rtl/rot_loader.sv
// Feeds the nibble rotation register: accepts a masked 32-bit word and replays it over one
// full revolution as data_in/set_data pairs, keeping the free-running phase counter.
module rot_loader #(
    parameter int unsigned SLOT_BITS = 4,
    parameter int unsigned NUM_SLOTS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [SLOT_BITS*NUM_SLOTS-1:0] wr_data,
    input  logic [NUM_SLOTS-1:0]           wr_mask,
    output logic [$clog2(NUM_SLOTS)-1:0]   phase,
    output logic [SLOT_BITS-1:0]           rot_data,
    output logic                           rot_set,
    output logic                           busy,
    output logic                           load_done
);

    localparam int unsigned PhW   = $clog2(NUM_SLOTS);
    localparam int unsigned WordW = SLOT_BITS * NUM_SLOTS;
    localparam logic [PhW-1:0] LastCount = PhW'(NUM_SLOTS - 1);

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                 state_q, state_d;
    logic [PhW-1:0]         phase_q, phase_d;
    logic [PhW-1:0]         count_q, count_d;
    logic [WordW-1:0]       act_word_q, act_word_d;
    logic [NUM_SLOTS-1:0]   act_mask_q, act_mask_d;
    logic [WordW-1:0]       pend_word_q, pend_word_d;
    logic [NUM_SLOTS-1:0]   pend_mask_q, pend_mask_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [SLOT_BITS-1:0]   rot_data_q, rot_data_d;
    logic                   rot_set_q, rot_set_d;
    logic                   busy_q, busy_d;
    logic                   load_done_q, load_done_d;
    logic                   xfer;
    logic [PhW-1:0]         nxt_slot;

    assign wr_ready  = !pend_valid_q;
    assign xfer      = wr_valid && wr_ready;
    assign phase     = phase_q;
    assign rot_data  = rot_data_q;
    assign rot_set   = rot_set_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + PhW'(1);
        count_d      = count_q;
        act_word_d   = act_word_q;
        act_mask_d   = act_mask_q;
        pend_word_d  = pend_word_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    act_word_d = wr_data;
                    act_mask_d = wr_mask;
                    count_d    = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (count_q == LastCount) begin
                    // Chain the next word with no bubble; pending has priority since
                    // wr_ready is low whenever it holds a word.
                    if (pend_valid_q) begin
                        act_word_d   = pend_word_q;
                        act_mask_d   = pend_mask_q;
                        pend_valid_d = 1'b0;
                        count_d      = '0;
                    end else if (xfer) begin
                        act_word_d = wr_data;
                        act_mask_d = wr_mask;
                        count_d    = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    count_d = count_q + PhW'(1);
                    if (xfer) begin
                        pend_word_d  = wr_data;
                        pend_mask_d  = wr_mask;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are computed for next cycle's phase; set_data at
        // phase p writes slot p+1.
        nxt_slot    = phase_d + PhW'(1);
        busy_d      = (state_d == StLoad);
        rot_set_d   = (state_d == StLoad) && act_mask_d[nxt_slot];
        load_done_d = (state_d == StLoad) && (count_d == LastCount);
        rot_data_d  = rot_data_q;
        if (rot_set_d) begin
            rot_data_d = act_word_d[SLOT_BITS*int'(nxt_slot) +: SLOT_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            count_q      <= '0;
            act_word_q   <= '0;
            act_mask_q   <= '0;
            pend_word_q  <= '0;
            pend_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            rot_data_q   <= '0;
            rot_set_q    <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            act_word_q   <= act_word_d;
            act_mask_q   <= act_mask_d;
            pend_word_q  <= pend_word_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
            rot_data_q   <= rot_data_d;
            rot_set_q    <= rot_set_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
        end
    end

endmodule

// File: tb/tb_rot_loader.sv
// Directed bench for rot_loader with a small model of the downstream rotation ring.
module tb_rot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [7:0]  wr_mask;
    logic [2:0]  phase;
    logic [3:0]  rot_data;
    logic        rot_set;
    logic        busy;
    logic        load_done;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_phase;
    logic [2:0] ring_slot;
    logic [3:0] ring [8];

    rot_loader #(.SLOT_BITS(4), .NUM_SLOTS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .phase     (phase),
        .rot_data  (rot_data),
        .rot_set   (rot_set),
        .busy      (busy),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    // Independent phase reference and rotation-register model (reset together with the DUT).
    assign ring_slot = exp_phase + 3'd1;
    always @(posedge clk) begin
        if (rst) begin
            exp_phase <= 3'd0;
            for (int i = 0; i < 8; i++) ring[i] <= 4'h0;
        end else begin
            exp_phase <= exp_phase + 3'd1;
            if (rot_set) ring[ring_slot] <= rot_data;
        end
    end

    function automatic logic [31:0] ring_word();
        return {ring[7], ring[6], ring[5], ring[4], ring[3], ring[2], ring[1], ring[0]};
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] s);
        logic [31:0] sh;
        sh = w >> (4 * s);
        return sh[3:0];
    endfunction

    task automatic test_reset();
        logic [2:0] ph;
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
        checks++; if (rot_set !== 1'b0) begin errors++; $display("FAIL reset_rot_set got %b exp 0", rot_set); end
        checks++; if (rot_data !== 4'h0) begin errors++; $display("FAIL reset_rot_data got %h exp 0", rot_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        ph = 3'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ph = ph + 3'd1;
            checks++; if (phase !== ph) begin errors++; $display("FAIL idle_phase cyc %0d got %0d exp %0d", i, phase, ph); end
            checks++; if (rot_set !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
                errors++; $display("FAIL idle_flags cyc %0d got set=%b busy=%b rdy=%b exp 0 0 1", i, rot_set, busy, wr_ready);
            end
        end
    endtask

    task automatic test_load_full();
        for (int j = 0; j < 8 && exp_phase != 3'd2; j++) @(negedge clk);
        wr_valid = 1'b1; wr_data = 32'h76543210; wr_mask = 8'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (phase !== exp_phase) begin errors++; $display("FAIL full_phase cyc %0d got %0d exp %0d", i, phase, exp_phase); end
            checks++; if (rot_set !== 1'b1) begin errors++; $display("FAIL full_rot_set cyc %0d got %b exp 1", i, rot_set); end
            checks++; if (rot_data !== {1'b0, ring_slot}) begin errors++; $display("FAIL full_rot_data cyc %0d got %h exp %h", i, rot_data, ring_slot); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy cyc %0d got %b exp 1", i, busy); end
            checks++; if (load_done !== (i == 7)) begin errors++; $display("FAIL full_load_done cyc %0d got %b exp %b", i, load_done, i == 7); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || rot_set !== 1'b0) begin errors++; $display("FAIL full_end got busy=%b set=%b exp 0 0", busy, rot_set); end
        checks++; if (ring_word() !== 32'h76543210) begin errors++; $display("FAIL full_ring got %h exp 76543210", ring_word()); end
        checks++; if (ring[exp_phase] !== {1'b0, exp_phase}) begin errors++; $display("FAIL full_ring_out got %h exp %h", ring[exp_phase], exp_phase); end
    endtask

    task automatic test_mask();
        logic exp_set;
        wr_valid = 1'b1; wr_data = 32'hFFFFFFFF; wr_mask = 8'h0F;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_set = (ring_slot < 3'd4);
            checks++; if (rot_set !== exp_set) begin errors++; $display("FAIL mask_rot_set cyc %0d got %b exp %b", i, rot_set, exp_set); end
            if (exp_set) begin
                checks++; if (rot_data !== 4'hF) begin errors++; $display("FAIL mask_rot_data cyc %0d got %h exp f", i, rot_data); end
            end
            checks++; if (load_done !== (i == 7)) begin errors++; $display("FAIL mask_load_done cyc %0d got %b exp %b", i, load_done, i == 7); end
            @(negedge clk);
        end
        checks++; if (ring_word() !== 32'h7654FFFF) begin errors++; $display("FAIL mask_ring got %h exp 7654ffff", ring_word()); end
    endtask

    task automatic test_mask_zero();
        wr_valid = 1'b1; wr_data = 32'h00000000; wr_mask = 8'h00;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rot_set !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL mask0_flags cyc %0d got set=%b busy=%b exp 0 1", i, rot_set, busy);
            end
            checks++; if (load_done !== (i == 7)) begin errors++; $display("FAIL mask0_load_done cyc %0d got %b exp %b", i, load_done, i == 7); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask0_end_busy got %b exp 0", busy); end
        checks++; if (ring_word() !== 32'h7654FFFF) begin errors++; $display("FAIL mask0_ring got %h exp 7654ffff", ring_word()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        logic [31:0] cur;
        w[0] = 32'h89ABCDEF; w[1] = 32'h01234567; w[2] = 32'hFEDCBA98;
        wr_valid = 1'b1; wr_data = w[0]; wr_mask = 8'hFF;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b exp 1", wr_ready); end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++; if (busy !== (k <= 24)) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy, k <= 24); end
            checks++; if (load_done !== (k == 8 || k == 16 || k == 24)) begin
                errors++; $display("FAIL b2b_load_done k=%0d got %b", k, load_done);
            end
            checks++; if (wr_ready !== (k == 1 || k == 9 || k >= 17)) begin
                errors++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, wr_ready, k == 1 || k == 9 || k >= 17);
            end
            if (k <= 24) begin
                cur = w[(k - 1) / 8];
                checks++; if (rot_set !== 1'b1 || rot_data !== nib(cur, ring_slot)) begin
                    errors++; $display("FAIL b2b_rot k=%0d got set=%b data=%h exp 1 %h", k, rot_set, rot_data, nib(cur, ring_slot));
                end
            end
            if (k == 9 || k == 17 || k == 25) begin
                cur = w[(k - 9) / 8];
                checks++; if (ring_word() !== cur) begin errors++; $display("FAIL b2b_ring k=%0d got %h exp %h", k, ring_word(), cur); end
            end
            if (k == 1) wr_data = w[1];
            if (k == 2) wr_data = w[2];
            if (k == 10) wr_valid = 1'b0;
        end
    endtask

    task automatic test_xfer_on_last();
        logic [31:0] x1, x2, cur;
        x1 = 32'h13579BDF; x2 = 32'h2468ACE0;
        wr_valid = 1'b1; wr_data = x1; wr_mask = 8'hFF;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++; if (busy !== (k <= 16)) begin errors++; $display("FAIL last_busy k=%0d got %b exp %b", k, busy, k <= 16); end
            checks++; if (load_done !== (k == 8 || k == 16)) begin errors++; $display("FAIL last_load_done k=%0d got %b", k, load_done); end
            if (k <= 16) begin
                cur = (k <= 8) ? x1 : x2;
                checks++; if (rot_set !== 1'b1 || rot_data !== nib(cur, ring_slot)) begin
                    errors++; $display("FAIL last_rot k=%0d got set=%b data=%h exp 1 %h", k, rot_set, rot_data, nib(cur, ring_slot));
                end
            end
            if (k == 1) wr_valid = 1'b0;
            if (k == 8) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL last_ready got %b exp 1", wr_ready); end
                wr_valid = 1'b1; wr_data = x2;
            end
            if (k == 9) wr_valid = 1'b0;
        end
        checks++; if (ring_word() !== x2) begin errors++; $display("FAIL last_ring got %h exp %h", ring_word(), x2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] z3;
        z3 = 32'h5A5AC3C3;
        wr_valid = 1'b1; wr_data = 32'hCAFEBABE; wr_mask = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) wr_data = 32'h0BADF00D;
            if (k == 2) wr_valid = 1'b0;
            if (k >= 2) begin
                checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready k=%0d got %b exp 0", k, wr_ready); end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rot_set !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL rmid_flags got set=%b busy=%b done=%b exp 0 0 0", rot_set, busy, load_done);
        end
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rmid_phase got %0d exp 0", phase); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_pending got ready=%b exp 1", wr_ready); end
        wr_valid = 1'b1; wr_data = z3; wr_mask = 8'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rot_set !== 1'b1 || rot_data !== nib(z3, ring_slot)) begin
                errors++; $display("FAIL rmid_rot cyc %0d got set=%b data=%h exp 1 %h", i, rot_set, rot_data, nib(z3, ring_slot));
            end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_end_busy got %b exp 0", busy); end
        checks++; if (ring_word() !== z3) begin errors++; $display("FAIL rmid_ring got %h exp %h", ring_word(), z3); end
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_mask();
        test_mask_zero();
        test_back_to_back();
        test_xfer_on_last();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rot_loader.md
Name: rot_loader

Overview:
- Upstream feeder for the baby_vga nibble rotation register (32-bit ring, 8 slots x 4 bits, one slot presented per clock).
- Accepts a 32-bit word from the peripheral register interface through a valid/ready handshake, with a per-nibble write mask.
- Drives the rotation register's data-in/set-data pair for one full revolution so that each slot receives its correct nibble.
- Maintains the rotation phase counter, which the pixel path also uses.

Parameters:
- SLOT_BITS, 4: nibble width; must match the rotation register.
- NUM_SLOTS, 8: slots per revolution; power of two; SLOT_BITS*NUM_SLOTS = 32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high; the rotation register is reset in the same cycle (its rst_n = ~rst)
- wr_valid  in  1  word offered
- wr_ready  out  1  word can be accepted this cycle
- wr_data  in  32  word; slot s = wr_data[4s+3:4s]
- wr_mask  in  8  bit s=1: overwrite slot s; 0: preserve slot s
- phase  out  3  slot index currently on the rotation register output
- rot_data  out  4  to rotation register data_in
- rot_set  out  1  to rotation register set_data
- busy  out  1  load in progress
- load_done  out  1  one-cycle pulse on the final load cycle

Behaviour:
- Reset (rst=1 at edge):
  - phase=0, state=IDLE, pending buffer empty.
  - rot_set=0, rot_data=0, busy=0, load_done=0, wr_ready=1 in the cycle after reset.
  - rst overrides all other inputs.
  - A load in progress is abandoned with no further rot_set; the partially written ring is not restored.
- phase:
  - Increments by 1 every non-reset cycle, wrapping 7 -> 0.
  - Free-running, independent of load activity.
- Slot mapping:
  - rot_set=1 in a cycle with phase=p replaces slot (p+1) mod 8.
  - Therefore rot_data = active_word nibble at slot (phase+1) mod 8.
- Handshake:
  - Transfer occurs when wr_valid && wr_ready at the edge.
  - wr_ready = !pending_valid (combinational).
  - wr_data and wr_mask are sampled only on transfer.
- States:
  - IDLE:
    - busy=0, rot_set=0.
    - On transfer, the word and mask are latched into the active register; go to LOAD with count=0.
  - LOAD:
    - busy=1; count 0..7 increments each cycle.
    - rot_set = active_mask[(phase+1) mod 8].
    - Loading starts in the cycle after transfer, at any phase; no phase alignment wait.
    - Cycle count=7: load_done=1.
      - If pending is valid: pending moves to active, pending is cleared, and LOAD restarts at count=0 next cycle (no bubble).
      - Else if a transfer happens this same cycle: the word goes straight to active and LOAD restarts.
      - Otherwise: go to IDLE.
    - Transfer during LOAD with count<7: the word goes to pending (one entry). wr_ready drops the next cycle.
- Latency and throughput:
  - Word accepted at edge A -> rot_set window covers cycles A+1..A+8.
  - Every slot is updated by the end of cycle A+8.
  - Sustained throughput is one word per 8 cycles.
- Mask:
  - wr_mask=0 still runs the full 8-cycle LOAD with rot_set held at 0. load_done still pulses.
- When rot_set=0, rot_data holds the last driven value; its value is don't-care for checking.

Test Plan:
- Reset, then idle 20 cycles -> phase counts 0..7 repeatedly; rot_set=0, busy=0, wr_ready=1.
- Accept 0x76543210, mask 0xFF, at a phase=2 cycle -> rot_set high for 8 cycles, with rot_data = slot (phase+1) each cycle. Load_done occurs on the 8th cycle. On the following revolution the rotation register output equals phase (slot s shows s).
- Accept mask 0x0F, word 0xFFFFFFFF, over ring contents 0x76543210 -> rot_set only when (phase+1) mod 8 < 4. Ring becomes 0x7654FFFF.
- Back-to-back: three words offered continuously -> first accepted, second held in pending, wr_ready=0 until its promotion. Loads run with no idle cycle between them, load_done every 8 cycles, and all three words are applied in order.
- Transfer on the count=7 cycle with pending empty -> next LOAD begins the following cycle; busy never drops.
- rst asserted at count=3 -> the next cycle has rot_set=0, busy=0, phase=0, pending cleared; a new word afterwards loads normally.
